// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and frame helpers.
package uart_pkg;

    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;
    localparam int PAR_MARK  = 3;
    localparam int PAR_SPACE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Data is zero-extended to 9 bits by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int ptype);
        case (ptype)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int frame_bits(input int data_bits, input int ptype, input int stop_bits);
        return 1 + data_bits + ((ptype != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick marks the last clock of the current bit.
module uart_baud_tick #(
    parameter int P_DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [P_DIV_W-1:0] load_val,
    output logic               tick,
    output logic [P_DIV_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter with integrated bit-period divider, parity, stop bits and break.
module uart_tx_baud
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS   = 8,
    parameter int P_PARITY_TYPE = 0,
    parameter int P_STOP_BITS   = 1,
    parameter int P_MSB_FIRST   = 0,
    parameter int P_DIV_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [P_DIV_W-1:0]     i_baud_div,
    input  logic [P_DATA_BITS-1:0] i_tx_data,
    input  logic                   i_tx_valid,
    output logic                   o_tx_ready,
    input  logic                   i_break,
    output logic                   o_serial_tx,
    output logic                   o_busy,
    output logic                   o_frame_done
);

    localparam int         FRAME_BITS = frame_bits(P_DATA_BITS, P_PARITY_TYPE, P_STOP_BITS);
    localparam logic [3:0] LAST_DATA  = 4'(P_DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(P_STOP_BITS - 1);

    if (P_DATA_BITS < 5 || P_DATA_BITS > 9 || P_PARITY_TYPE < 0 || P_PARITY_TYPE > 4 ||
        P_STOP_BITS < 1 || P_STOP_BITS > 2 || P_MSB_FIRST < 0 || P_MSB_FIRST > 1 ||
        P_DIV_W < 1 || FRAME_BITS > 13) begin : g_param_err
        $error("uart_tx_baud: illegal parameter value");
    end

    state_t                 state, state_nxt;
    logic [3:0]             bit_idx, bit_idx_nxt;
    logic [P_DATA_BITS-1:0] data_q, data_sh;
    logic [P_DIV_W-1:0]     div_q, load_val, count;
    logic                   par_q, brk_frame, brk_frame_nxt;
    logic                   load, tick, accept, brk_exit, cnt_zero_nxt;
    logic                   serial_nxt, done_nxt;

    uart_baud_tick #(.P_DIV_W(P_DIV_W)) u_tick (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (count)
    );

    assign accept   = (state == ST_IDLE) && !i_break && i_tx_valid;
    assign brk_exit = (state == ST_BREAK) && !i_break;

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        load        = 1'b0;
        load_val    = div_q;
        case (state)
            ST_IDLE: begin
                if (i_break) begin
                    state_nxt = ST_BREAK;
                end else if (i_tx_valid) begin
                    state_nxt = ST_START;
                    load      = 1'b1;
                    load_val  = i_baud_div;
                end
            end
            ST_START: if (tick) begin
                state_nxt   = ST_DATA;
                bit_idx_nxt = '0;
                load        = 1'b1;
            end
            ST_DATA: if (tick) begin
                load = 1'b1;
                if (bit_idx == LAST_DATA) begin
                    bit_idx_nxt = '0;
                    state_nxt   = (P_PARITY_TYPE == PAR_NONE) ? ST_STOP : ST_PARITY;
                end else begin
                    bit_idx_nxt = bit_idx + 4'd1;
                end
            end
            ST_PARITY: if (tick) begin
                state_nxt   = ST_STOP;
                bit_idx_nxt = '0;
                load        = 1'b1;
            end
            ST_STOP: if (tick) begin
                if (bit_idx == LAST_STOP) begin
                    state_nxt = ST_IDLE;
                end else begin
                    bit_idx_nxt = bit_idx + 4'd1;
                    load        = 1'b1;
                end
            end
            ST_BREAK: if (!i_break) begin
                state_nxt   = ST_STOP;
                bit_idx_nxt = '0;
                load        = 1'b1;
                load_val    = i_baud_div;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so each bit appears with its state.
    always_comb begin
        data_sh       = (P_MSB_FIRST != 0) ? (data_q << bit_idx_nxt) : (data_q >> bit_idx_nxt);
        serial_nxt    = 1'b1;
        case (state_nxt)
            ST_START:  serial_nxt = 1'b0;
            ST_DATA:   serial_nxt = (P_MSB_FIRST != 0) ? data_sh[P_DATA_BITS-1] : data_sh[0];
            ST_PARITY: serial_nxt = par_q;
            ST_BREAK:  serial_nxt = 1'b0;
            default:   serial_nxt = 1'b1;
        endcase
        brk_frame_nxt = (state_nxt == ST_BREAK) ? 1'b1 : (accept ? 1'b0 : brk_frame);
        cnt_zero_nxt  = load ? (load_val == '0) : (count <= P_DIV_W'(1));
        done_nxt      = (state_nxt == ST_STOP) && (bit_idx_nxt == LAST_STOP) &&
                        cnt_zero_nxt && !brk_frame_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            bit_idx      <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            div_q        <= '0;
            brk_frame    <= 1'b0;
            o_serial_tx  <= 1'b1;
            o_tx_ready   <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_idx      <= bit_idx_nxt;
            brk_frame    <= brk_frame_nxt;
            o_serial_tx  <= serial_nxt;
            o_tx_ready   <= (state_nxt == ST_IDLE);
            o_busy       <= (state_nxt != ST_IDLE);
            o_frame_done <= done_nxt;
            if (accept) begin
                data_q <= i_tx_data;
                par_q  <= parity_bit(9'(i_tx_data), P_PARITY_TYPE);
            end
            if (accept || brk_exit)
                div_q <= i_baud_div;
        end
    end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor checks each frame at its done pulse.
module tb_uart_tx_baud;

    localparam int NDUT = 7;
    localparam int MSB_C [NDUT] = '{0, 1, 0, 0, 0, 0, 0};
    localparam int PAR_C [NDUT] = '{0, 0, 1, 2, 3, 4, 1};
    localparam int STP_C [NDUT] = '{1, 1, 1, 1, 1, 1, 2};

    typedef struct {
        int          k;
        string       nm;
        logic [15:0] w;     // first transmitted bit at w[n-1]
        int          n;
        int          dv;
        int          gap;   // expected idle clocks before the frame, -1 = don't care
    } exp_t;

    typedef struct {
        string nm;
        int    act;
        int    exp;
    } pt_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [15:0]     dv  [NDUT];
    logic [7:0]      dat [NDUT];
    logic            vld [NDUT];
    logic            brk [NDUT];
    logic [NDUT-1:0] rdy, ser, busy, done;

    exp_t exp_q[$];
    pt_t  pt_q[$];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_baud #(
            .P_DATA_BITS   (8),
            .P_PARITY_TYPE (PAR_C[g]),
            .P_STOP_BITS   (STP_C[g]),
            .P_MSB_FIRST   (MSB_C[g]),
            .P_DIV_W       (16)
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_baud_div   (dv[g]),
            .i_tx_data    (dat[g]),
            .i_tx_valid   (vld[g]),
            .o_tx_ready   (rdy[g]),
            .i_break      (brk[g]),
            .o_serial_tx  (ser[g]),
            .o_busy       (busy[g]),
            .o_frame_done (done[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: the only process that touches the counters.
    logic [255:0] hist     [NDUT];
    int           bcnt     [NDUT];
    int           idle     [NDUT];
    int           last_gap [NDUT];
    bit           pend     [NDUT];

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            hist[k] = '1; bcnt[k] = 0; idle[k] = 1000; last_gap[k] = 1000; pend[k] = 0;
        end
        forever begin
            @(negedge clk);
            while (pt_q.size() > 0) begin
                pt_t p;
                p = pt_q.pop_front();
                chk(p.nm, p.act, p.exp);
            end
            for (int k = 0; k < NDUT; k++) begin
                if (pend[k]) begin
                    chk($sformatf("post_frame%0d{ser,rdy,busy}", k), int'({ser[k], rdy[k], busy[k]}), 3'b110);
                    pend[k] = 0;
                end
                hist[k] = {hist[k][254:0], ser[k]};
                if (busy[k]) begin
                    if (bcnt[k] == 0) last_gap[k] = idle[k];
                    bcnt[k]++;
                    idle[k] = 0;
                end else begin
                    bcnt[k] = 0;
                    idle[k]++;
                end
                if (done[k]) begin
                    int idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].k == k) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_done%0d", k), 1, 0);
                    end else begin
                        exp_t e;
                        int   len, bad;
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        len = e.n * (e.dv + 1);
                        bad = -1;
                        chk({e.nm, "_len"}, bcnt[k], len);
                        for (int j = 0; j < len; j++)
                            if (bad < 0 && hist[k][len-1-j] !== e.w[e.n-1-j/(e.dv+1)]) bad = j;
                        chk({e.nm, "_wave_first_bad_clk"}, bad, -1);
                        if (e.gap >= 0) chk({e.nm, "_gap"}, last_gap[k], e.gap);
                        pend[k] = 1;
                    end
                end
            end
        end
    end

    task automatic expect_frame(input int k, input string nm, input logic [15:0] w,
                                input int n, input int d_v, input int gap);
        exp_t e;
        e.k = k; e.nm = nm; e.w = w; e.n = n; e.dv = d_v; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic point(input string nm, input int act, input int exp);
        pt_t p;
        p.nm = nm; p.act = act; p.exp = exp;
        pt_q.push_back(p);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int k, input logic [7:0] d, input int d_v, input bit keep);
        int to = 0;
        dat[k] = d; dv[k] = 16'(d_v); vld[k] = 1'b1;
        while (!rdy[k] && to < 1000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 1000) point($sformatf("ready_timeout%0d", k), 0, 1);
        @(negedge clk);
        if (!keep) vld[k] = 1'b0;
        dat[k] = ~d;
    endtask

    task automatic wait_idle();
        int to = 0;
        while (exp_q.size() > 0 && to < 3000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 3000) point("frame_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lo, hi;
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            dv[k] = 16'd3; dat[k] = 8'h00; vld[k] = 1'b0; brk[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            point($sformatf("reset%0d{ser,rdy,busy,done}", k), int'({ser[k], rdy[k], busy[k], done[k]}), 4'b1100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Bit order, div=3 and div=2
        expect_frame(0, "a5_lsb", 16'b0101001011, 10, 3, -1); send(0, 8'hA5, 3, 0);
        expect_frame(1, "a5_msb", 16'b0101001011, 10, 3, -1); send(1, 8'hA5, 3, 0);
        wait_idle();
        expect_frame(0, "01_lsb", 16'b0100000001, 10, 2, -1); send(0, 8'h01, 2, 0);
        expect_frame(1, "01_msb", 16'b0000000011, 10, 2, -1); send(1, 8'h01, 2, 0);
        wait_idle();

        // Parity modes and two stop bits, div=0
        expect_frame(2, "07_even",  16'b01110000011,  11, 0, -1); send(2, 8'h07, 0, 0);
        expect_frame(3, "07_odd",   16'b01110000001,  11, 0, -1); send(3, 8'h07, 0, 0);
        expect_frame(4, "07_mark",  16'b01110000011,  11, 0, -1); send(4, 8'h07, 0, 0);
        expect_frame(5, "07_space", 16'b01110000001,  11, 0, -1); send(5, 8'h07, 0, 0);
        expect_frame(6, "07_even2", 16'b011100000111, 12, 0, -1); send(6, 8'h07, 0, 0);
        wait_idle();
        expect_frame(2, "03_even", 16'b01100000001, 11, 0, -1); send(2, 8'h03, 0, 0);
        expect_frame(3, "03_odd",  16'b01100000011, 11, 0, -1); send(3, 8'h03, 0, 0);
        wait_idle();

        // Back-to-back with valid held high
        expect_frame(0, "55_b2b", 16'b0101010101, 10, 1, -1);
        expect_frame(0, "aa_b2b", 16'b0010101011, 10, 1, 1);
        send(0, 8'h55, 1, 1);
        send(0, 8'hAA, 1, 0);
        wait_idle();

        // Divider change mid-frame applies only to the next frame
        expect_frame(0, "0f_div3", 16'b0111100001, 10, 3, -1); send(0, 8'h0F, 3, 0);
        repeat (10) @(negedge clk);
        dv[0] = 16'd7;
        expect_frame(0, "f0_div7", 16'b0000011111, 10, 7, -1); send(0, 8'hF0, 7, 0);
        wait_idle();

        // Break with valid also high: 50 low clocks, one 2-clock stop bit, no done
        brk[0] = 1'b1; vld[0] = 1'b1; dat[0] = 8'h12; dv[0] = 16'd1;
        lo = 0;
        repeat (50) begin
            @(negedge clk);
            if (!ser[0] && !rdy[0] && busy[0]) lo++;
        end
        brk[0] = 1'b0; vld[0] = 1'b0;
        point("break_low_clks", lo, 50);
        hi = 0;
        repeat (2) begin
            @(negedge clk);
            if (ser[0] && !rdy[0] && busy[0]) hi++;
        end
        point("break_stop_clks", hi, 2);
        @(negedge clk);
        point("break_end{ser,rdy,busy}", int'({ser[0], rdy[0], busy[0]}), 3'b110);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a data bit, then a clean resend
        send(0, 8'h3C, 3, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 point("reset_async{ser,rdy,busy}", int'({ser[0], rdy[0], busy[0]}), 3'b110);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_frame(0, "3c_after_rst", 16'b0001111001, 10, 3, -1); send(0, 8'h3C, 3, 0);
        wait_idle();

        point("frames_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
